// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared types and constants for fifo_wr_arbiter.
//   state_e      arbiter state (ARB re-arbitrates, LOCK holds a packet grant)
//   src_w()      width of the source-ID tag
//   CREDIT_INC/CREDIT_DEC  credit counter step sizes
package fifo_wr_arb_pkg;
  typedef enum logic {ARB, LOCK} state_e;
  localparam logic CREDIT_INC = 1'b1;
  localparam logic CREDIT_DEC = 1'b1;
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: combinational round-robin picker.
//   i_req    request vector
//   i_ptr    index with highest priority this cycle
//   o_grant  one-hot grant (zero when no request)
//   o_idx    encoded index of the granted request
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx
);
  always_comb begin
    int j;
    logic found;
    o_grant = '0;
    o_idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && i_req[j]) begin
        found = 1'b1;
        o_grant[j] = 1'b1;
        o_idx = W'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter sharing one FIFO among NUM_REQ requesters.
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   per-requester handshake; req_data payload; req_last packet end
//   fifo_wr_en/din    registered write port, din = {src_id, data}
//   fifo_pop          one entry left the FIFO this cycle
//   credits           free FIFO entries; grant_id last accepted source
//   credit_err        sticky pop-while-empty error
// Optional macro FIFO_WR_ARB_PKT_LOCK_EN keeps the grant on a requester until req_last.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  localparam int SRC_W = src_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH+SRC_W-1:0]   fifo_din,
  input  logic                          fifo_pop,
  output logic [ADDR_WIDTH:0]           credits,
  output logic [SRC_W-1:0]              grant_id,
  output logic                          credit_err
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [ADDR_WIDTH:0] r_credits;
  logic [SRC_W-1:0] r_ptr, r_grant_id, w_idx, w_ptr_nxt;
  logic [NUM_REQ-1:0] w_req, w_grant;
  logic [DATA_WIDTH+SRC_W-1:0] r_din;
  logic r_wr_en, r_credit_err, w_hs, w_lock, w_lock_nxt;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  state_e r_state, w_state_nxt;
  logic w_last;
  assign w_last = req_last[w_idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB;
    else r_state <= w_state_nxt;
  end
  always_comb w_state_nxt = !w_hs ? r_state : (w_last ? ARB : LOCK);
  assign w_lock = r_state == LOCK;
  assign w_lock_nxt = w_state_nxt == LOCK;
`else
  logic w_unused_last;
  assign w_unused_last = ^req_last;
  assign w_lock = 1'b0;
  assign w_lock_nxt = 1'b0;
`endif

  // While locked the pointer still sits on the owner, so masking to it pins the grant.
  always_comb begin
    w_req = (r_credits == '0) ? '0 :
            (w_lock ? req_valid & (NUM_REQ'(1) << r_ptr) : req_valid);
  end

  rr_select #(.N(NUM_REQ), .W(SRC_W)) u_sel (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx)
  );

  assign w_hs = |w_grant;
  assign w_ptr_nxt = w_lock_nxt ? w_idx :
                     (w_idx == SRC_W'(NUM_REQ - 1)) ? '0 : w_idx + SRC_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credits <= DEPTH;
      r_credit_err <= 1'b0;
      r_wr_en <= 1'b0;
      r_din <= '0;
      r_grant_id <= '0;
      r_ptr <= '0;
    end else begin
      if (w_hs && !fifo_pop) r_credits <= r_credits - {{ADDR_WIDTH{1'b0}}, CREDIT_DEC};
      else if (fifo_pop && !w_hs && r_credits != DEPTH) r_credits <= r_credits + {{ADDR_WIDTH{1'b0}}, CREDIT_INC};
      if (fifo_pop && r_credits == DEPTH) r_credit_err <= 1'b1;
      r_wr_en <= w_hs;
      if (w_hs) begin
        r_din <= {w_idx, req_data[w_idx*DATA_WIDTH +: DATA_WIDTH]};
        r_grant_id <= w_idx;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign req_ready = w_grant;
  assign fifo_wr_en = r_wr_en;
  assign fifo_din = r_din;
  assign credits = r_credits;
  assign grant_id = r_grant_id;
  assign credit_err = r_credit_err;
endmodule
